// File: rtl/mem_access_unit_if.sv
// External memory bus between mem_access_unit (master) and the memory (slave).
// Valid/ready request channel, then an rvalid read-return strobe.
interface mem_access_unit_if;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_write, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_write, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bridge from the core data port to a wait-stated memory bus, with timeout.
// Optional MEM_MISALIGN_TRAP_EN: misaligned word accesses fault without touching the bus.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_read_i,
  input  logic              req_write_i,
  input  logic              req_byte_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic              stall_o,
  output logic              fault_o,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             byte_q, byte_d;
  logic [1:0]       lane_q, lane_d;
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             fault_q, fault_d;

  logic        req;
  logic        misalign;
  logic [7:0]  lane_byte [4];
  logic [31:0] load_data;

  assign req = req_read_i | req_write_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = ~req_byte_i & (addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = bus.bus_rdata[8*gi +: 8];
    end
  endgenerate

  assign load_data = byte_q ? {24'h0, lane_byte[lane_q]} : bus.bus_rdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_data_d = read_data_q;
    fault_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (misalign) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            write_d = req_write_i;
            byte_d  = req_byte_i;
            lane_d  = addr_i[1:0];
            addr_d  = addr_i[31:2];
            wdata_d = req_byte_i ? {4{write_data_i[7:0]}} : write_data_i;
            be_d    = req_byte_i ? (4'b0001 << addr_i[1:0]) : 4'hF;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A handshake in the final counted cycle takes priority over the abort.
        if (bus.bus_ready) begin
          cnt_d   = '0;
          state_d = write_q ? DONE : RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
          if (!write_q) read_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.bus_rvalid) begin
          read_data_d = load_data;
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          fault_d     = 1'b1;
          read_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'h0;
      read_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_data_q <= read_data_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.bus_valid = (state_q == REQ);
  assign bus.bus_write = write_q;
  assign bus.bus_addr  = {addr_q, 2'b00};
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;

  // The core is not running under reset, so never hold it stalled then.
  assign stall_o     = rst_n & req & (state_q != DONE);
  assign fault_o     = fault_q;
  assign read_data_o = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mem_access_unit;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_read, req_write, req_byte;
  logic [31:0] addr, write_data, read_data;
  logic        stall, fault;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_read_i   (req_read),
    .req_write_i  (req_write),
    .req_byte_i   (req_byte),
    .addr_i       (addr),
    .write_data_i (write_data),
    .read_data_o  (read_data),
    .stall_o      (stall),
    .fault_o      (fault),
    .bus          (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          stalls;
    logic        flt;
    logic [31:0] rd;
    int          valids;
  } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acts 2 time units after each rising edge.
  int ready_wait = 0, rvalid_wait = 0, rdy_cnt = 0, rv_cnt = 0;
  bit rv_pending = 0, last_write = 0;

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      bus.bus_ready  = 1'b0;
      bus.bus_rvalid = 1'b0;
      rv_pending     = 0;
      rdy_cnt        = 0;
    end else begin
      if (bus.bus_rvalid) begin
        bus.bus_rvalid = 1'b0;
        rv_pending     = 0;
      end
      if (bus.bus_ready) begin
        bus.bus_ready = 1'b0;
        if (!last_write) begin
          rv_pending = 1;
          rv_cnt     = 0;
        end
      end
      if (bus.bus_valid) begin
        bus.bus_ready = (rdy_cnt >= ready_wait);
        last_write    = bus.bus_write;
        rdy_cnt++;
      end else begin
        rdy_cnt = 0;
      end
      if (rv_pending) begin
        bus.bus_rvalid = (rv_cnt >= rvalid_wait);
        rv_cnt++;
      end
    end
  end

  // Monitor
  int stall_cnt = 0, valid_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      valid_cnt = 0;
    end else begin
      if (bus.bus_valid) valid_cnt++;
      if (bus.bus_valid && bus.bus_ready) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected actual=handshake@0x%08h expected=none", bus.bus_addr);
        end else begin
          bus_exp_t b;
          b = bus_q.pop_front();
          chk("bus_write", {31'h0, bus.bus_write}, {31'h0, b.wr});
          chk("bus_addr", bus.bus_addr, b.addr);
          chk("bus_be", {28'h0, bus.bus_be}, {28'h0, b.be});
          if (b.wr) chk("bus_wdata", bus.bus_wdata, b.wdata);
        end
      end
      if (req_read || req_write) begin
        if (stall) begin
          stall_cnt++;
        end else if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=completion expected=none");
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          $display("TXN done addr=0x%08h stalls=%0d fault=%0b read_data=0x%08h valid_cycles=%0d",
                   addr, stall_cnt, fault, read_data, valid_cnt);
          chk("stall_cycles", stall_cnt, d.stalls);
          chk("fault", {31'h0, fault}, {31'h0, d.flt});
          chk("read_data", read_data, d.rd);
          chk("valid_cycles", valid_cnt, d.valids);
          stall_cnt = 0;
          valid_cnt = 0;
        end
      end else if (fault) begin
        checks++;
        errors++;
        $display("FAIL fault_outside_done actual=1 expected=0");
      end
    end
  end

  task automatic access(input logic wr, input logic byt, input logic [31:0] a, input logic [31:0] wd,
                        input int rw, input int vw, input logic [31:0] rdat,
                        input logic exp_bus, input logic [31:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewd, input int estall, input logic efault,
                        input logic [31:0] erd, input int evalid);
    bus_exp_t  b;
    done_exp_t d;
    bit        done_seen = 0;
    ready_wait     = rw;
    rvalid_wait    = vw;
    rv_pending     = 0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = rdat;
    if (exp_bus) begin
      b.wr = wr; b.addr = eaddr; b.be = ebe; b.wdata = ewd;
      bus_q.push_back(b);
    end
    d.stalls = estall; d.flt = efault; d.rd = erd; d.valids = evalid;
    done_q.push_back(d);
    req_write  = wr;
    req_read   = ~wr;
    req_byte   = byt;
    addr       = a;
    write_data = wd;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!stall) begin
        done_seen = 1;
        break;
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout actual=still_stalled expected=done addr=0x%08h", a);
    end
    @(posedge clk);
    #1;
    req_read  = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=no_finish expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    req_read       = 1'b0;
    req_write      = 1'b0;
    req_byte       = 1'b0;
    addr           = '0;
    write_data     = '0;
    bus.bus_ready  = 1'b0;
    bus.bus_rvalid = 1'b0;
    bus.bus_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_bus_valid", {31'h0, bus.bus_valid}, 32'h0);
    chk("rst_bus_write", {31'h0, bus.bus_write}, 32'h0);
    chk("rst_bus_addr", bus.bus_addr, 32'h0);
    chk("rst_bus_wdata", bus.bus_wdata, 32'h0);
    chk("rst_bus_be", {28'h0, bus.bus_be}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     wr byt addr          wdata         rw  vw  rdata         bus eaddr         be    ewdata        st flt rd            valids
    access(1, 0, 32'h0000_1000, 32'hDEADBEEF, 0,  0,  32'h0,        1,  32'h0000_1000, 4'hF, 32'hDEADBEEF, 2, 0, 32'h0,        1);
    access(0, 1, 32'h0000_2003, 32'h0,        0,  2,  32'hAABBCCDD, 1,  32'h0000_2000, 4'h8, 32'h0,        5, 0, 32'h0000_00AA, 1);
    access(1, 1, 32'h0000_3001, 32'h12345677, 0,  0,  32'h0,        1,  32'h0000_3000, 4'h2, 32'h77777777, 2, 0, 32'h0000_00AA, 1);
    access(0, 0, 32'h0000_5000, 32'h0,        2,  0,  32'h11223344, 1,  32'h0000_5000, 4'hF, 32'h0,        5, 0, 32'h11223344, 3);
    access(0, 1, 32'h0000_6001, 32'h0,        1,  1,  32'h55667788, 1,  32'h0000_6000, 4'h2, 32'h0,        5, 0, 32'h0000_0077, 2);
    access(0, 0, 32'h0000_7000, 32'h0,        99, 0,  32'h12121212, 0,  32'h0,         4'h0, 32'h0,        9, 1, 32'h0,        8);
    access(0, 0, 32'h0000_8000, 32'h0,        0,  0,  32'hCAFEF00D, 1,  32'h0000_8000, 4'hF, 32'h0,        3, 0, 32'hCAFEF00D, 1);
    access(1, 0, 32'h0000_D000, 32'hA5A5A5A5, 1,  0,  32'h0,        1,  32'h0000_D000, 4'hF, 32'hA5A5A5A5, 3, 0, 32'hCAFEF00D, 2);
    access(0, 0, 32'h0000_C004, 32'h0,        7,  0,  32'h0BADBEEF, 1,  32'h0000_C004, 4'hF, 32'h0,        10, 0, 32'h0BADBEEF, 8);

    // Reset asserted while the load waits in RESP.
    ready_wait     = 0;
    rvalid_wait    = 99;
    rv_pending     = 0;
    bus.bus_rdata  = 32'h0;
    begin
      bus_exp_t b;
      b.wr = 1'b0; b.addr = 32'h0000_9000; b.be = 4'hF; b.wdata = 32'h0;
      bus_q.push_back(b);
    end
    req_read = 1'b1;
    req_byte = 1'b0;
    addr     = 32'h0000_9000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("resp_bus_valid", {31'h0, bus.bus_valid}, 32'h0);
    chk("resp_stall", {31'h0, stall}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_valid", {31'h0, bus.bus_valid}, 32'h0);
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    chk("midrst_read_data", read_data, 32'h0);
    $display("TXN reset asserted during RESP addr=0x%08h", addr);
    req_read = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(0, 1, 32'h0000_A002, 32'h0,        0,  0,  32'h00C30000, 1,  32'h0000_A000, 4'h4, 32'h0,        3, 0, 32'h0000_00C3, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    access(0, 0, 32'h0000_4002, 32'h0,        0,  0,  32'h99887766, 0,  32'h0,         4'h0, 32'h0,        1, 1, 32'h0000_00C3, 0);
`else
    access(0, 0, 32'h0000_4002, 32'h0,        0,  0,  32'h99887766, 1,  32'h0000_4000, 4'hF, 32'h0,        3, 0, 32'h99887766, 1);
`endif
    access(0, 0, 32'h0000_B000, 32'h0,        0,  99, 32'h00000001, 1,  32'h0000_B000, 4'hF, 32'h0,        10, 1, 32'h0,       1);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", bus_q.size(), 32'h0);
    chk("done_q_drained", done_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
